// File: rtl/postconv_pkg.sv
// Shared PostConvUnit constants and the ReLU/saturate clamp used by the
// requantisation and neighbouring stages.
package postconv_pkg;

  localparam int ACC_W   = 32;
  localparam int OUT_W   = 16;
  localparam int LENGTH  = 32;
  localparam int CH_NUM  = 16;
  localparam int SHIFT_W = 5;

  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};

  // Negative values become 0, values above OUT_MAX saturate, so the MSB of
  // the result is always 0 and unsigned comparisons downstream stay valid.
  function automatic logic [OUT_W-1:0] relu_sat(input logic signed [ACC_W:0] v);
    logic signed [ACC_W:0] lim;
    logic [OUT_W-1:0]      r;
    lim = $signed({{(ACC_W+1-OUT_W){1'b0}}, OUT_MAX});
    if (v[ACC_W]) begin
      r = '0;
    end else if (v > lim) begin
      r = OUT_MAX;
    end else begin
      r = v[OUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/relu_quant_bias_rf.sv
// Per-channel bias register file: one synchronous write port, one
// asynchronous read port. A same-cycle write is seen by the read only next cycle.
module relu_quant_bias_rf #(
  parameter int ACC_W  = 32,
  parameter int CH_NUM = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [$clog2(CH_NUM)-1:0] wr_addr,
  input  logic [ACC_W-1:0]          wr_data,
  input  logic [$clog2(CH_NUM)-1:0] rd_addr,
  output logic [ACC_W-1:0]          rd_data
);

  logic [ACC_W-1:0] mem_r [CH_NUM];

  // Bias storage; soft clear deliberately leaves the entries alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/relu_quant.sv
// Bias add, rounded arithmetic shift, ReLU and saturation; 3-cycle pipeline.
// Define RELU_QUANT_ROUND_EN for round-half-up, otherwise the shift truncates.
module relu_quant #(
  parameter int ACC_W   = postconv_pkg::ACC_W,
  parameter int OUT_W   = postconv_pkg::OUT_W,
  parameter int LENGTH  = postconv_pkg::LENGTH,
  parameter int CH_NUM  = postconv_pkg::CH_NUM,
  parameter int SHIFT_W = postconv_pkg::SHIFT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      soft_clr,
  input  logic                      cfg_we,
  input  logic [$clog2(CH_NUM)-1:0] cfg_addr,
  input  logic [ACC_W-1:0]          cfg_bias,
  input  logic [SHIFT_W-1:0]        cfg_shift,
  input  logic [ACC_W-1:0]          acc_in,
  input  logic                      in_valid,
  output logic [OUT_W-1:0]          data_out,
  output logic                      out_valid,
  output logic [$clog2(CH_NUM)-1:0] ch_out,
  output logic                      frame_done
);

  import postconv_pkg::*;

  localparam int CH_W  = $clog2(CH_NUM);
  localparam int PIX_N = LENGTH * LENGTH;
  localparam int PIX_W = $clog2(PIX_N);

  logic [PIX_W-1:0]      pix_cnt_r;
  logic [CH_W-1:0]       ch_cnt_r;
  logic                  accept_s, pix_last_s, ch_last_s;
  logic [ACC_W-1:0]      bias_s;

  logic                  s1_valid_r, s1_last_r;
  logic [CH_W-1:0]       s1_ch_r;
  logic signed [ACC_W:0] s1_sum_r;

  logic                  s2_valid_r, s2_last_r;
  logic [CH_W-1:0]       s2_ch_r;
  logic signed [ACC_W:0] s2_val_r;

  // One guard bit above the sum so the rounding constant cannot overflow.
  logic signed [ACC_W+1:0] s2_pre_s, s2_shr_s;

  assign accept_s   = in_valid & ~soft_clr;
  assign pix_last_s = (pix_cnt_r == PIX_W'(PIX_N - 1));
  assign ch_last_s  = (ch_cnt_r == CH_W'(CH_NUM - 1));

  relu_quant_bias_rf #(.ACC_W(ACC_W), .CH_NUM(CH_NUM)) u_bias_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (cfg_we),
    .wr_addr (cfg_addr),
    .wr_data (cfg_bias),
    .rd_addr (ch_cnt_r),
    .rd_data (bias_s)
  );

  // Raster position of the next accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_r <= '0;
      ch_cnt_r  <= '0;
    end else if (soft_clr) begin
      pix_cnt_r <= '0;
      ch_cnt_r  <= '0;
    end else if (accept_s) begin
      if (pix_last_s) begin
        pix_cnt_r <= '0;
        ch_cnt_r  <= ch_last_s ? '0 : ch_cnt_r + CH_W'(1);
      end else begin
        pix_cnt_r <= pix_cnt_r + PIX_W'(1);
      end
    end
  end

  // S1: widened bias add, tag captured alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_ch_r    <= '0;
      s1_sum_r   <= '0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_last_r <= pix_last_s & ch_last_s;
        s1_ch_r   <= ch_cnt_r;
        s1_sum_r  <= {acc_in[ACC_W-1], acc_in} + {bias_s[ACC_W-1], bias_s};
      end
    end
  end

`ifdef RELU_QUANT_ROUND_EN
  logic [ACC_W+1:0] round_s;

  // Half-LSB of the shifted result; nothing to add for a zero shift.
  always_comb begin
    round_s = '0;
    if (cfg_shift != '0) begin
      round_s = {{(ACC_W+1){1'b0}}, 1'b1} << (cfg_shift - SHIFT_W'(1));
    end else begin
      round_s = '0;
    end
    s2_pre_s = {s1_sum_r[ACC_W], s1_sum_r} + round_s;
    s2_shr_s = s2_pre_s >>> cfg_shift;
  end
`else
  // Plain arithmetic shift, i.e. truncation toward minus infinity.
  always_comb begin
    s2_pre_s = {s1_sum_r[ACC_W], s1_sum_r};
    s2_shr_s = s2_pre_s >>> cfg_shift;
  end
`endif

  // S2: shifted value; after any rounding shift it fits back in ACC_W+1 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_ch_r    <= '0;
      s2_val_r   <= '0;
    end else if (soft_clr) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_last_r <= s1_last_r;
        s2_ch_r   <= s1_ch_r;
        s2_val_r  <= s2_shr_s[ACC_W:0];
      end
    end
  end

  // S3: clamp into the output register; data and tag hold between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      data_out   <= '0;
      ch_out     <= '0;
    end else if (soft_clr) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= s2_valid_r;
      frame_done <= s2_valid_r & s2_last_r;
      if (s2_valid_r) begin
        data_out <= relu_sat(s2_val_r);
        ch_out   <= s2_ch_r;
      end
    end
  end

endmodule

// File: tb/tb_relu_quant.sv
// Directed bench for relu_quant with LENGTH=4, CH_NUM=2 (16 pixels per channel).
module tb_relu_quant;

`ifdef RELU_QUANT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        soft_clr = 1'b0;
  logic        cfg_we = 1'b0;
  logic [0:0]  cfg_addr = 1'b0;
  logic [31:0] cfg_bias = 32'd0;
  logic [4:0]  cfg_shift = 5'd0;
  logic [31:0] acc_in = 32'd0;
  logic        in_valid = 1'b0;
  logic [15:0] data_out;
  logic        out_valid;
  logic [0:0]  ch_out;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] acc;
    logic [31:0] bias;
    logic [4:0]  sh;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic [0:0]  ch;
    logic        fd;
  } obs_t;

  obs_t obs_q[$];

  relu_quant #(.ACC_W(32), .OUT_W(16), .LENGTH(4), .CH_NUM(2), .SHIFT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_bias(cfg_bias), .cfg_shift(cfg_shift),
    .acc_in(acc_in), .in_valid(in_valid), .data_out(data_out),
    .out_valid(out_valid), .ch_out(ch_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (out_valid) obs_q.push_back('{d: data_out, ch: ch_out, fd: frame_done});
    if (frame_done && !out_valid) begin
      checks++;
      errors++;
      $display("FAIL frame_done_without_valid: frame_done=1 out_valid=0");
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    soft_clr = 1'b1;
    tick();
    soft_clr = 1'b0;
  endtask

  task automatic wr_bias(input logic [0:0] a, input logic [31:0] b);
    cfg_we = 1'b1; cfg_addr = a; cfg_bias = b;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [2:0] lat;
    pulse_clr();
    wr_bias(1'b0, v.bias);
    cfg_shift = v.sh;
    acc_in = v.acc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk); lat[2] = out_valid;
    @(negedge clk); lat[1] = out_valid;
    @(negedge clk); lat[0] = out_valid;
    chk($sformatf("vec%0d_latency", idx), {61'd0, lat}, 64'd1);
    chk($sformatf("vec%0d_data", idx), {48'd0, data_out}, {48'd0, v.exp});
    @(negedge clk); @(negedge clk);
    chk($sformatf("vec%0d_hold", idx), {47'd0, out_valid, data_out}, {48'd0, v.exp});
  endtask

  task automatic run_frame(input string name);
    int gap;
    obs_q.delete();
    for (int i = 0; i < 32; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      acc_in = 32'd0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
    end
    for (int w = 0; w < 20 && obs_q.size() < 32; w++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk({name, "_count"}, 64'(obs_q.size()), 64'd32);
    for (int i = 0; i < obs_q.size() && i < 32; i++) begin
      chk($sformatf("%s_beat%0d", name, i),
          {46'd0, obs_q[i].d, obs_q[i].ch, obs_q[i].fd},
          {46'd0, (i < 16) ? 16'd0 : 16'd5, (i < 16) ? 1'b0 : 1'b1, (i == 31)});
    end
  endtask

  task automatic ten_beats();
    obs_q.delete();
    acc_in = 32'd0; in_valid = 1'b1;
    repeat (10) tick();
  endtask

  vec_t vecs[11];
  int   n0;

  initial begin
    vecs[0]  = '{32'h0000_0108, 32'h0000_0010, 5'd4,  RND ? 16'h0012 : 16'h0011};
    vecs[1]  = '{-32'sd1000,    32'd0,         5'd0,  16'h0000};
    vecs[2]  = '{32'h7FFF_FFF0, 32'h0000_0100, 5'd0,  16'h7FFF};
    vecs[3]  = '{32'd100,       -32'sd30,      5'd1,  16'd35};
    vecs[4]  = '{32'd7,         32'd0,         5'd1,  RND ? 16'd4 : 16'd3};
    vecs[5]  = '{-32'sd7,       32'd0,         5'd1,  16'd0};
    vecs[6]  = '{32'h0000_7FFF, 32'd0,         5'd0,  16'h7FFF};
    vecs[7]  = '{32'h0000_7FFE, 32'd2,         5'd0,  16'h7FFF};
    vecs[8]  = '{32'h8000_0000, 32'h8000_0000, 5'd31, 16'd0};
    vecs[9]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd31, RND ? 16'd2 : 16'd1};
    vecs[10] = '{32'h0001_2345, 32'd0,         5'd4,  16'h1234};

    // Reset values.
    @(negedge clk);
    chk("reset_outputs", {45'd0, data_out, out_valid, ch_out, frame_done}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Bias write coinciding with a beat: that beat sees the old bias.
    pulse_clr();
    wr_bias(1'b0, 32'd0);
    cfg_shift = 5'd0;
    repeat (3) tick();
    obs_q.delete();
    cfg_we = 1'b1; cfg_addr = 1'b0; cfg_bias = 32'd7;
    acc_in = 32'd10; in_valid = 1'b1;
    tick();
    cfg_we = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int w = 0; w < 10 && obs_q.size() < 2; w++) @(negedge clk);
    chk("bias_wr_count", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() >= 2) begin
      chk("bias_wr_old", {48'd0, obs_q[0].d}, 64'd10);
      chk("bias_wr_new", {48'd0, obs_q[1].d}, 64'd17);
    end

    // Two-channel frame with random gaps.
    pulse_clr();
    wr_bias(1'b0, 32'd0);
    wr_bias(1'b1, 32'd5);
    run_frame("frame_gaps");

    // soft_clr after 10 beats; the in_valid raised with it is dropped.
    pulse_clr();
    ten_beats();
    soft_clr = 1'b1; in_valid = 1'b1;
    tick();
    soft_clr = 1'b0; in_valid = 1'b0;
    repeat (6) tick();
    chk("softclr_drain", 64'(obs_q.size()), 64'd8);
    run_frame("frame_after_clr");

    // Asynchronous reset mid-frame.
    ten_beats();
    rst_n = 1'b0; in_valid = 1'b0;
    n0 = obs_q.size();
    @(negedge clk);
    chk("reset_mid_outputs", {45'd0, data_out, out_valid, ch_out, frame_done}, 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("reset_no_inflight", 64'(obs_q.size()), 64'(n0));
    wr_bias(1'b1, 32'd5);
    run_frame("frame_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
